alu_bypass: RTL and testbench



---
 rtl/alu_bypass_pkg.sv | 37 +++
 rtl/alu_bypass_if.sv | 37 +++
 rtl/alu_bypass_operand_bypass.sv | 28 ++
 rtl/alu_bypass.sv | 123 ++++++++++++
 tb/tb_alu_bypass.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_bypass_pkg.sv
// Shared execute-stage definitions: data/register-index widths and ALU_Control opcodes.
// Reused by the EXE and MEM stages so opcode values live in exactly one place.
package alu_bypass_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CTRL_W = 6;

    typedef enum logic [CTRL_W-1:0] {
        OP_SLL   = 6'h00,
        OP_SRL   = 6'h02,
        OP_SRA   = 6'h03,
        OP_SLLV  = 6'h04,
        OP_SRLV  = 6'h06,
        OP_SRAV  = 6'h07,
        OP_LUI   = 6'h0F,
        OP_MFHI  = 6'h10,
        OP_MTHI  = 6'h11,
        OP_MFLO  = 6'h12,
        OP_MTLO  = 6'h13,
        OP_MULT  = 6'h18,
        OP_MULTU = 6'h19,
        OP_DIV   = 6'h1A,
        OP_DIVU  = 6'h1B,
        OP_ADD   = 6'h20,
        OP_ADDU  = 6'h21,
        OP_SUB   = 6'h22,
        OP_SUBU  = 6'h23,
        OP_AND   = 6'h24,
        OP_OR    = 6'h25,
        OP_XOR   = 6'h26,
        OP_NOR   = 6'h27,
        OP_SLT   = 6'h2A,
        OP_SLTU  = 6'h2B
    } alu_op_e;

endpackage

// File: rtl/alu_bypass_if.sv
// Issue-stage to execute-stage bundle: operands, bypass sources, control and results.
// master = issue/decode side, slave = the ALU.
interface alu_bypass_if
    import alu_bypass_pkg::*;
();
    logic              STALL;
    logic [CTRL_W-1:0] ALU_Control;
    logic [REG_W-1:0]  ShiftAmount;
    logic [REG_W-1:0]  RegisterA;
    logic [REG_W-1:0]  RegisterB;
    logic [DATA_W-1:0] OperandA;
    logic [DATA_W-1:0] OperandB;
    logic [REG_W-1:0]  WriteRegister1stPri;
    logic [DATA_W-1:0] WriteData1stPri;
    logic              Valid1stPri;
    logic [REG_W-1:0]  WriteRegister2ndPri;
    logic [DATA_W-1:0] WriteData2ndPri;
    logic              Valid2ndPri;
    logic [DATA_W-1:0] ALU_result;
    logic [DATA_W-1:0] HI_OUT;
    logic [DATA_W-1:0] LO_OUT;

    modport master (
        output STALL, ALU_Control, ShiftAmount, RegisterA, RegisterB, OperandA, OperandB,
               WriteRegister1stPri, WriteData1stPri, Valid1stPri,
               WriteRegister2ndPri, WriteData2ndPri, Valid2ndPri,
        input  ALU_result, HI_OUT, LO_OUT
    );

    modport slave (
        input  STALL, ALU_Control, ShiftAmount, RegisterA, RegisterB, OperandA, OperandB,
               WriteRegister1stPri, WriteData1stPri, Valid1stPri,
               WriteRegister2ndPri, WriteData2ndPri, Valid2ndPri,
        output ALU_result, HI_OUT, LO_OUT
    );

endinterface

// File: rtl/alu_bypass_operand_bypass.sv
// Two-priority forwarding mux for one source operand; also usable for store-data forwarding.
// Register 0 is hard-wired zero and is never forwarded.
module operand_bypass
    import alu_bypass_pkg::*;
(
    input  logic [REG_W-1:0]  reg_idx,
    input  logic [DATA_W-1:0] reg_data,
    input  logic [REG_W-1:0]  wr_reg_1st,
    input  logic [DATA_W-1:0] wr_data_1st,
    input  logic              wr_vld_1st,
    input  logic [REG_W-1:0]  wr_reg_2nd,
    input  logic [DATA_W-1:0] wr_data_2nd,
    input  logic              wr_vld_2nd,
    output logic [DATA_W-1:0] operand
);

    logic nonzero;
    logic hit_1st;
    logic hit_2nd;

    assign nonzero = (reg_idx != '0);
    assign hit_1st = nonzero && wr_vld_1st && (wr_reg_1st == reg_idx);
    assign hit_2nd = nonzero && wr_vld_2nd && (wr_reg_2nd == reg_idx);

    assign operand = hit_1st ? wr_data_1st :
                     hit_2nd ? wr_data_2nd : reg_data;

endmodule

// File: rtl/alu_bypass.sv
// Execute-stage ALU with two-level operand bypass and HI/LO multiply/divide registers.
// Forwarding is enabled by defining ALU_FORWARDING_EN; otherwise operands come straight from the register file.
module alu_bypass
    import alu_bypass_pkg::*;
(
    input  logic         CLK,
    input  logic         RESET,
    alu_bypass_if.slave  bus
);

    logic              fwd_vld_1st;
    logic              fwd_vld_2nd;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

`ifdef ALU_FORWARDING_EN
    assign fwd_vld_1st = bus.Valid1stPri;
    assign fwd_vld_2nd = bus.Valid2ndPri;
`else
    assign fwd_vld_1st = 1'b0;
    assign fwd_vld_2nd = 1'b0;
`endif

    operand_bypass u_byp_a (
        .reg_idx     (bus.RegisterA),
        .reg_data    (bus.OperandA),
        .wr_reg_1st  (bus.WriteRegister1stPri),
        .wr_data_1st (bus.WriteData1stPri),
        .wr_vld_1st  (fwd_vld_1st),
        .wr_reg_2nd  (bus.WriteRegister2ndPri),
        .wr_data_2nd (bus.WriteData2ndPri),
        .wr_vld_2nd  (fwd_vld_2nd),
        .operand     (op_a)
    );

    operand_bypass u_byp_b (
        .reg_idx     (bus.RegisterB),
        .reg_data    (bus.OperandB),
        .wr_reg_1st  (bus.WriteRegister1stPri),
        .wr_data_1st (bus.WriteData1stPri),
        .wr_vld_1st  (fwd_vld_1st),
        .wr_reg_2nd  (bus.WriteRegister2ndPri),
        .wr_data_2nd (bus.WriteData2ndPri),
        .wr_vld_2nd  (fwd_vld_2nd),
        .operand     (op_b)
    );

    logic signed [DATA_W-1:0]   a_s;
    logic signed [DATA_W-1:0]   b_s;
    logic signed [2*DATA_W-1:0] prod_s;
    logic [2*DATA_W-1:0]        prod_u;
    logic signed [DATA_W-1:0]   quot_s;
    logic signed [DATA_W-1:0]   rem_s;
    logic [DATA_W-1:0]          quot_u;
    logic [DATA_W-1:0]          rem_u;
    logic                       b_zero;

    assign a_s    = op_a;
    assign b_s    = op_b;
    assign prod_s = {{DATA_W{op_a[DATA_W-1]}}, op_a} * {{DATA_W{op_b[DATA_W-1]}}, op_b};
    assign prod_u = {{DATA_W{1'b0}}, op_a} * {{DATA_W{1'b0}}, op_b};
    assign b_zero = (op_b == '0);
    // Divider inputs are forced to a safe divisor so a zero B never reaches the operator.
    assign quot_s = a_s / (b_zero ? 32'sd1 : b_s);
    assign rem_s  = a_s % (b_zero ? 32'sd1 : b_s);
    assign quot_u = op_a / (b_zero ? 32'd1 : op_b);
    assign rem_u  = op_a % (b_zero ? 32'd1 : op_b);

    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic [DATA_W-1:0] hi_nxt;
    logic [DATA_W-1:0] lo_nxt;
    logic              hilo_we;
    logic [DATA_W-1:0] result;

    always_comb begin
        result  = '0;
        hi_nxt  = hi_q;
        lo_nxt  = lo_q;
        hilo_we = 1'b0;
        case (bus.ALU_Control)
            OP_SLL:   result = op_b << bus.ShiftAmount;
            OP_SRL:   result = op_b >> bus.ShiftAmount;
            OP_SRA:   result = b_s >>> bus.ShiftAmount;
            OP_SLLV:  result = op_b << op_a[4:0];
            OP_SRLV:  result = op_b >> op_a[4:0];
            OP_SRAV:  result = b_s >>> op_a[4:0];
            OP_LUI:   result = {op_b[15:0], 16'h0000};
            OP_MFHI:  result = hi_q;
            OP_MFLO:  result = lo_q;
            OP_MTHI:  begin hilo_we = 1'b1; hi_nxt = op_a; end
            OP_MTLO:  begin hilo_we = 1'b1; lo_nxt = op_a; end
            OP_MULT:  begin hilo_we = 1'b1; {hi_nxt, lo_nxt} = prod_s; end
            OP_MULTU: begin hilo_we = 1'b1; {hi_nxt, lo_nxt} = prod_u; end
            OP_DIV:   begin hilo_we = !b_zero; hi_nxt = rem_s; lo_nxt = quot_s; end
            OP_DIVU:  begin hilo_we = !b_zero; hi_nxt = rem_u; lo_nxt = quot_u; end
            OP_ADD, OP_ADDU: result = op_a + op_b;
            OP_SUB, OP_SUBU: result = op_a - op_b;
            OP_AND:   result = op_a & op_b;
            OP_OR:    result = op_a | op_b;
            OP_XOR:   result = op_a ^ op_b;
            OP_NOR:   result = ~(op_a | op_b);
            OP_SLT:   result = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
            OP_SLTU:  result = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
            default:  result = '0;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (hilo_we && !bus.STALL) begin
            hi_q <= hi_nxt;
            lo_q <= lo_nxt;
        end
    end

    assign bus.ALU_result = result;
    assign bus.HI_OUT     = hi_q;
    assign bus.LO_OUT     = lo_q;

endmodule

// File: tb/tb_alu_bypass.sv
// Directed bench for alu_bypass: a per-cycle reference model plus hand-computed literal checks.
// Follows ALU_FORWARDING_EN the same way the design does.
module tb_alu_bypass;
    import alu_bypass_pkg::*;

`ifdef ALU_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RESET;
    int   checks   = 0;
    int   failures = 0;
    bit   started  = 1'b0;

    alu_bypass_if bus();

    alu_bypass dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // Reference model state
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;

    function automatic logic [31:0] resolve(input logic [4:0] r, input logic [31:0] rf);
        if (FWD && r != 5'd0 && bus.Valid1stPri && bus.WriteRegister1stPri == r) return bus.WriteData1stPri;
        if (FWD && r != 5'd0 && bus.Valid2ndPri && bus.WriteRegister2ndPri == r) return bus.WriteData2ndPri;
        return rf;
    endfunction

    function automatic logic [31:0] model_result();
        logic [31:0] a, b;
        int sa, sb;
        a  = resolve(bus.RegisterA, bus.OperandA);
        b  = resolve(bus.RegisterB, bus.OperandB);
        sa = int'(a);
        sb = int'(b);
        case (bus.ALU_Control)
            6'h00: return b << bus.ShiftAmount;
            6'h02: return b >> bus.ShiftAmount;
            6'h03: return 32'(sb >>> bus.ShiftAmount);
            6'h04: return b << a[4:0];
            6'h06: return b >> a[4:0];
            6'h07: return 32'(sb >>> a[4:0]);
            6'h0F: return {b[15:0], 16'h0};
            6'h10: return m_hi;
            6'h12: return m_lo;
            6'h20, 6'h21: return a + b;
            6'h22, 6'h23: return a - b;
            6'h24: return a & b;
            6'h25: return a | b;
            6'h26: return a ^ b;
            6'h27: return ~(a | b);
            6'h2A: return (sa < sb) ? 32'd1 : 32'd0;
            6'h2B: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge CLK or posedge RESET) begin
        logic [31:0] a, b;
        longint      ps;
        logic [63:0] pu;
        a = resolve(bus.RegisterA, bus.OperandA);
        b = resolve(bus.RegisterB, bus.OperandB);
        if (RESET) begin
            m_hi <= 32'h0;
            m_lo <= 32'h0;
        end else if (!bus.STALL) begin
            case (bus.ALU_Control)
                6'h11: m_hi <= a;
                6'h13: m_lo <= a;
                6'h18: begin
                    ps = longint'(int'(a)) * longint'(int'(b));
                    m_hi <= ps[63:32];
                    m_lo <= ps[31:0];
                end
                6'h19: begin
                    pu = 64'(a) * 64'(b);
                    m_hi <= pu[63:32];
                    m_lo <= pu[31:0];
                end
                6'h1A: if (b != 0) begin
                    m_lo <= 32'(int'(a) / int'(b));
                    m_hi <= 32'(int'(a) % int'(b));
                end
                6'h1B: if (b != 0) begin
                    m_lo <= a / b;
                    m_hi <= a % b;
                end
                default: ;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (started) begin
            chk("model_result", bus.ALU_result, model_result());
            chk("model_hi", bus.HI_OUT, m_hi);
            chk("model_lo", bus.LO_OUT, m_lo);
        end
    end

    task automatic drive(input logic [5:0] ctrl, input logic [4:0] sh,
                         input logic [4:0] ra, input logic [4:0] rb,
                         input logic [31:0] oa, input logic [31:0] ob, input logic stall);
        @(posedge CLK);
        #1;
        bus.ALU_Control = ctrl;
        bus.ShiftAmount = sh;
        bus.RegisterA   = ra;
        bus.RegisterB   = rb;
        bus.OperandA    = oa;
        bus.OperandB    = ob;
        bus.STALL       = stall;
        bus.Valid1stPri = 1'b0;
        bus.Valid2ndPri = 1'b0;
        #1;
    endtask

    task automatic set_fwd(input logic [4:0] w1, input logic [31:0] d1, input logic v1,
                           input logic [4:0] w2, input logic [31:0] d2, input logic v2);
        bus.WriteRegister1stPri = w1;
        bus.WriteData1stPri     = d1;
        bus.Valid1stPri         = v1;
        bus.WriteRegister2ndPri = w2;
        bus.WriteData2ndPri     = d2;
        bus.Valid2ndPri         = v2;
        #1;
    endtask

    initial begin
        RESET = 1'b1;
        bus.STALL = 1'b0;
        bus.ALU_Control = 6'h21;
        bus.ShiftAmount = 5'd0;
        bus.RegisterA = 5'd0;
        bus.RegisterB = 5'd0;
        bus.OperandA = 32'h0;
        bus.OperandB = 32'h0;
        set_fwd(5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        started = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_hi", bus.HI_OUT, 32'h0);
        chk("reset_lo", bus.LO_OUT, 32'h0);
        @(negedge CLK);
        RESET = 1'b0;

        // Bypass priority, observed through ADDU with B = r0 = 0
        drive(6'h21, 5'd0, 5'd5, 5'd0, 32'hAAAA, 32'h0, 1'b0);
        set_fwd(5'd5, 32'h11, 1'b1, 5'd5, 32'h22, 1'b1);
        chk("byp_1st", bus.ALU_result, FWD ? 32'h11 : 32'hAAAA);
        set_fwd(5'd5, 32'h11, 1'b0, 5'd5, 32'h22, 1'b1);
        chk("byp_2nd", bus.ALU_result, FWD ? 32'h22 : 32'hAAAA);
        drive(6'h21, 5'd0, 5'd0, 5'd0, 32'hAAAA, 32'h0, 1'b0);
        set_fwd(5'd0, 32'h11, 1'b1, 5'd0, 32'h22, 1'b1);
        chk("byp_r0", bus.ALU_result, 32'hAAAA);
        drive(6'h21, 5'd0, 5'd3, 5'd3, 32'h1, 32'h2, 1'b0);
        set_fwd(5'd7, 32'h11, 1'b1, 5'd3, 32'h100, 1'b1);
        chk("byp_both_ops", bus.ALU_result, FWD ? 32'h200 : 32'h3);

        // Arithmetic and logic
        drive(6'h20, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h1, 1'b0);
        chk("add_wrap", bus.ALU_result, 32'h0);
        drive(6'h2A, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h1, 1'b0);
        chk("slt", bus.ALU_result, 32'h1);
        drive(6'h2B, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h1, 1'b0);
        chk("sltu", bus.ALU_result, 32'h0);
        drive(6'h03, 5'd4, 5'd0, 5'd0, 32'h0, 32'h80000000, 1'b0);
        chk("sra", bus.ALU_result, 32'hF8000000);
        drive(6'h0F, 5'd0, 5'd0, 5'd0, 32'h0, 32'h1234, 1'b0);
        chk("lui", bus.ALU_result, 32'h12340000);
        drive(6'h23, 5'd0, 5'd0, 5'd0, 32'h0, 32'h1, 1'b0);
        chk("subu_wrap", bus.ALU_result, 32'hFFFFFFFF);
        drive(6'h06, 5'd0, 5'd0, 5'd0, 32'h24, 32'h80000000, 1'b0);
        chk("srlv", bus.ALU_result, 32'h08000000);
        drive(6'h07, 5'd0, 5'd0, 5'd0, 32'h1F, 32'h80000000, 1'b0);
        chk("srav", bus.ALU_result, 32'hFFFFFFFF);
        drive(6'h27, 5'd0, 5'd0, 5'd0, 32'hF0F0F0F0, 32'h0F0F0000, 1'b0);
        chk("nor", bus.ALU_result, 32'h00000F0F);
        drive(6'h00, 5'd8, 5'd0, 5'd0, 32'h0, 32'h00ABCDEF, 1'b0);
        chk("sll", bus.ALU_result, 32'hABCDEF00);
        drive(6'h3F, 5'd0, 5'd0, 5'd0, 32'h5, 32'h6, 1'b0);
        chk("undef", bus.ALU_result, 32'h0);

        // Multiply then read back
        drive(6'h18, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h2, 1'b0);
        chk("mult_res", bus.ALU_result, 32'h0);
        drive(6'h10, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
        chk("mult_mfhi", bus.ALU_result, 32'hFFFFFFFF);
        chk("mult_lo", bus.LO_OUT, 32'hFFFFFFFE);
        drive(6'h19, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h2, 1'b0);
        drive(6'h12, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
        chk("multu_mflo", bus.ALU_result, 32'hFFFFFFFE);
        chk("multu_hi", bus.HI_OUT, 32'h1);

        // Divide
        drive(6'h1A, 5'd0, 5'd0, 5'd0, 32'hFFFFFFF9, 32'h2, 1'b0);
        drive(6'h12, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
        chk("div_lo", bus.ALU_result, 32'hFFFFFFFD);
        chk("div_hi", bus.HI_OUT, 32'hFFFFFFFF);
        drive(6'h1B, 5'd0, 5'd0, 5'd0, 32'h7, 32'h0, 1'b0);
        drive(6'h21, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
        chk("divu0_hi", bus.HI_OUT, 32'hFFFFFFFF);
        chk("divu0_lo", bus.LO_OUT, 32'hFFFFFFFD);
        drive(6'h1B, 5'd0, 5'd0, 5'd0, 32'd23, 32'd5, 1'b0);
        drive(6'h21, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
        chk("divu_lo", bus.LO_OUT, 32'd4);
        chk("divu_hi", bus.HI_OUT, 32'd3);

        // Stall holds HI/LO
        drive(6'h13, 5'd0, 5'd0, 5'd0, 32'h55, 32'h0, 1'b1);
        drive(6'h21, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
        chk("stall_lo", bus.LO_OUT, 32'd4);
        drive(6'h13, 5'd0, 5'd0, 5'd0, 32'h55, 32'h0, 1'b0);
        drive(6'h21, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
        chk("mtlo_lo", bus.LO_OUT, 32'h55);

        // Asynchronous reset between edges; ALU stays combinational
        drive(6'h21, 5'd0, 5'd0, 5'd0, 32'h3, 32'h4, 1'b0);
        RESET = 1'b1;
        #1;
        chk("areset_hi", bus.HI_OUT, 32'h0);
        chk("areset_lo", bus.LO_OUT, 32'h0);
        chk("areset_res", bus.ALU_result, 32'h7);
        @(negedge CLK);
        #1;
        RESET = 1'b0;
        drive(6'h11, 5'd0, 5'd0, 5'd0, 32'h1234, 32'h0, 1'b0);
        drive(6'h10, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
        chk("mthi_mfhi", bus.ALU_result, 32'h1234);
        chk("mthi_lo", bus.LO_OUT, 32'h0);

        @(posedge CLK);
        #1;
        started = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
